// File: rtl/fetch_loop_sequencer.sv
// Zero-overhead loop controller for the fetch stage: a small stack of
// {start, end, remaining} descriptors that steers fetch back to the body start.
module fetch_loop_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int CW    = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       cfg_valid,
  input  logic [AW-1:0]              cfg_start,
  input  logic [AW-1:0]              cfg_end,
  input  logic [CW-1:0]              cfg_count,
  output logic                       cfg_ready,
  input  logic                       flush,
  input  logic [AW-1:0]              fe_pc,
  input  logic                       fe_stall,
  output logic                       loop_o,
  output logic [AW-1:0]              pc_in_o,
  output logic                       active,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic [CW-1:0]              iter_o,
  output logic                       ovf_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_ONE = 1;
  localparam logic [DW-1:0] DEPTH_MAX = DEPTH[DW-1:0];
  localparam logic [CW-1:0] REM_ONE   = 1;

  logic [AW-1:0] r_start [DEPTH];
  logic [AW-1:0] r_end   [DEPTH];
  logic [CW-1:0] r_rem   [DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_ovf;

  logic          w_active;
  logic          w_full;
  logic [DW-1:0] w_topDepth;
  logic [IW-1:0] w_topIdx;
  logic [AW-1:0] w_topStart;
  logic [AW-1:0] w_topEnd;
  logic [CW-1:0] w_topRem;
  logic          w_match;
  logic          w_remMore;
  logic          w_advance;
  logic          w_dec;
  logic          w_pop;
  logic          w_accept;
  logic          w_pushWrite;
  logic [DW-1:0] w_baseDepth;
  logic [IW-1:0] w_pushIdx;

  assign w_active   = (r_depth != '0);
  assign w_full     = (r_depth == DEPTH_MAX);
  assign w_topDepth = r_depth - DEPTH_ONE;
  // Top index is forced to 0 when empty so the read never leaves the array.
  assign w_topIdx   = w_active ? w_topDepth[IW-1:0] : '0;
  assign w_topStart = r_start[w_topIdx];
  assign w_topEnd   = r_end[w_topIdx];
  assign w_topRem   = r_rem[w_topIdx];

  assign w_match   = w_active && (fe_pc == w_topEnd);
  assign w_remMore = (w_topRem > REM_ONE);
  assign w_advance = w_match && !fe_stall;
  assign w_dec     = w_advance && w_remMore;
  assign w_pop     = w_advance && !w_remMore;

  // A zero-count descriptor completes the handshake but never occupies a slot.
  assign w_accept    = cfg_valid && cfg_ready;
  assign w_pushWrite = w_accept && (cfg_count != '0);
  assign w_baseDepth = w_pop ? w_topDepth : r_depth;
  assign w_pushIdx   = w_baseDepth[IW-1:0];

  assign cfg_ready = !w_full;
  assign loop_o    = w_match && !flush && w_remMore;
  assign pc_in_o   = w_active ? w_topStart : '0;
  assign active    = w_active;
  assign depth_o   = r_depth;
  assign iter_o    = w_active ? w_topRem : '0;
  assign ovf_err   = r_ovf;

  // Pop resolves before push, so a same-edge pop+push replaces the top entry.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_rem[i]   <= '0;
      end
    end else begin
      if (cfg_valid && w_full) r_ovf <= 1'b1;
      if (flush) begin
        r_depth <= '0;
      end else begin
        if (w_dec) r_rem[w_topIdx] <= w_topRem - REM_ONE;
        if (w_pushWrite) begin
          r_start[w_pushIdx] <= cfg_start;
          r_end[w_pushIdx]   <= cfg_end;
          r_rem[w_pushIdx]   <= cfg_count;
          r_depth            <= w_baseDepth + DEPTH_ONE;
        end else begin
          r_depth <= w_baseDepth;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_loop_sequencer.sv
// Self-checking bench for fetch_loop_sequencer: directed spec scenarios plus
// randomized traffic, all compared against a queue-based descriptor-stack model.
module tb_fetch_loop_sequencer;

  localparam int DEPTH = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [15:0] cfg_start;
  logic [15:0] cfg_end;
  logic [15:0] cfg_count;
  logic        cfg_ready;
  logic        flush;
  logic [15:0] fe_pc;
  logic        fe_stall;
  logic        loop_o;
  logic [15:0] pc_in_o;
  logic        active;
  logic [2:0]  depth_o;
  logic [15:0] iter_o;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  fetch_loop_sequencer #(.DEPTH(DEPTH), .AW(16), .CW(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_start(cfg_start),
    .cfg_end  (cfg_end),
    .cfg_count(cfg_count),
    .cfg_ready(cfg_ready),
    .flush    (flush),
    .fe_pc    (fe_pc),
    .fe_stall (fe_stall),
    .loop_o   (loop_o),
    .pc_in_o  (pc_in_o),
    .active   (active),
    .depth_o  (depth_o),
    .iter_o   (iter_o),
    .ovf_err  (ovf_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: a queue of outstanding loops, last element is the innermost.
  typedef struct packed {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] r;
  } desc_t;

  desc_t stk[$];
  logic  mOvf;

  logic [38:0] got;
  assign got = {loop_o, pc_in_o, active, depth_o, iter_o, ovf_err, cfg_ready};

  function automatic logic [38:0] expected();
    logic        l;
    logic [15:0] p;
    logic [15:0] it;
    logic        a;
    a  = (stk.size() > 0);
    l  = 1'b0;
    p  = '0;
    it = '0;
    if (a) begin
      p  = stk[$].s;
      it = stk[$].r;
      l  = !flush && (fe_pc == stk[$].e) && (stk[$].r > 16'd1);
    end
    return {l, p, a, 3'(stk.size()), it, mOvf, (stk.size() < DEPTH)};
  endfunction

  // One clock of loop semantics: a body end either loops back or retires the loop,
  // then a new descriptor (if any) becomes the innermost loop.
  task automatic model_update();
    desc_t t;
    bit    wasFull;
    if (reset) begin
      stk.delete();
      mOvf = 1'b0;
      return;
    end
    wasFull = (stk.size() == DEPTH);
    if (cfg_valid && wasFull) mOvf = 1'b1;
    if (flush) begin
      stk.delete();
      return;
    end
    if (!fe_stall && stk.size() > 0 && fe_pc == stk[$].e) begin
      t = stk.pop_back();
      if (t.r > 16'd1) begin
        t.r = t.r - 16'd1;
        stk.push_back(t);
      end
    end
    if (cfg_valid && !wasFull && cfg_count != 16'd0) begin
      t.s = cfg_start;
      t.e = cfg_end;
      t.r = cfg_count;
      stk.push_back(t);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] s, input logic [15:0] e,
                               input logic [15:0] c, input logic [15:0] pc,
                               input logic st, input logic fl);
    @(negedge CLOCK_50);
    cfg_valid = v;
    cfg_start = s;
    cfg_end   = e;
    cfg_count = c;
    fe_pc     = pc;
    fe_stall  = st;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    stk.delete();
    mOvf = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_valid = 0; cfg_start = 0; cfg_end = 0; cfg_count = 0;
    fe_pc = 0; fe_stall = 0; flush = 0;
    stk.delete();
    mOvf = 1'b0;
    #3;
    checks++;
    if (got !== 39'd1) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, 39'd1);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic test_single_loop();
    logic [15:0] pcs [10] = '{4, 5, 6, 4, 5, 6, 4, 5, 6, 7};
    logic        expLoop [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] expIter [3] = '{16'd3, 16'd2, 16'd1};
    int k = 0;
    do_reset();
    applyStimulus(1, 4, 6, 3, 0, 0, 0);
    tick();
    foreach (pcs[i]) begin
      applyStimulus(0, 0, 0, 0, pcs[i], 0, 0);
      checks++;
      if (got !== expected()) begin
        errors++;
        $display("[TB] FAIL single_loop step %0d: got %h expected %h", i, got, expected());
      end
      if (pcs[i] == 16'd6) begin
        checks++;
        if ({loop_o, pc_in_o, iter_o} !== {expLoop[k], 16'd4, expIter[k]}) begin
          errors++;
          $display("[TB] FAIL single_loop_end %0d: got loop=%b pc_in=%0d iter=%0d expected loop=%b pc_in=4 iter=%0d",
                   k, loop_o, pc_in_o, iter_o, expLoop[k], expIter[k]);
        end
        k++;
      end
      tick();
    end
    checks++;
    if ({active, iter_o} !== {1'b0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL single_loop_exit: got active=%b iter=%0d expected 0 0", active, iter_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    applyStimulus(1, 4, 6, 2, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 6, 1, 0);
      checks++;
      if (got !== expected() || {loop_o, iter_o} !== {1'b1, 16'd2}) begin
        errors++;
        $display("[TB] FAIL stall_hold %0d: got %h expected %h", i, got, expected());
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 6, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 7, 0, 0);
    checks++;
    if (iter_o !== 16'd1 || got !== expected()) begin
      errors++;
      $display("[TB] FAIL stall_release: got iter=%0d expected 1", iter_o);
    end
    tick();
  endtask

  task automatic test_nested();
    logic [15:0] pcs [25] = '{2, 3, 4, 5, 6, 4, 5, 6, 7, 8, 9, 10,
                              2, 3, 4, 5, 6, 4, 5, 6, 7, 8, 9, 10, 11};
    do_reset();
    applyStimulus(1, 2, 10, 2, 0, 0, 0);
    tick();
    foreach (pcs[i]) begin
      if (pcs[i] == 16'd3) applyStimulus(1, 4, 6, 2, 3, 0, 0);
      else                 applyStimulus(0, 0, 0, 0, pcs[i], 0, 0);
      checks++;
      if (got !== expected()) begin
        errors++;
        $display("[TB] FAIL nested step %0d pc=%0d: got %h expected %h", i, pcs[i], got, expected());
      end
      tick();
    end
    checks++;
    if (depth_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL nested_exit: got depth=%0d expected 0", depth_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 16'(100 + i), 16'(100 + i), 2, 0, 0, 0);
      checks++;
      if (got !== expected()) begin
        errors++;
        $display("[TB] FAIL overflow push %0d: got %h expected %h", i, got, expected());
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({depth_o, ovf_err, cfg_ready} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL overflow_state: got depth=%0d ovf=%b ready=%b expected 4 1 0",
               depth_o, ovf_err, cfg_ready);
    end
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(1, 50, 50, 5, 103, 0, 1);
    checks++;
    if (loop_o !== 1'b0 || got !== expected()) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got loop=%b expected 0", loop_o);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({depth_o, active, ovf_err} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL flush_after: got depth=%0d active=%b ovf=%b expected 0 0 1",
               depth_o, active, ovf_err);
    end
    tick();
  endtask

  task automatic test_zero_count();
    logic expLoop [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    applyStimulus(1, 20, 22, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8, 8, 3, 0, 0, 0);
    checks++;
    if ({depth_o, cfg_ready, ovf_err} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL zero_count_push: got depth=%0d ready=%b ovf=%b expected 0 1 0",
               depth_o, cfg_ready, ovf_err);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 8, 0, 0);
      checks++;
      if (loop_o !== expLoop[i] || depth_o !== 3'd1 || got !== expected()) begin
        errors++;
        $display("[TB] FAIL one_instr_loop %0d: got loop=%b depth=%0d expected %b 1",
                 i, loop_o, depth_o, expLoop[i]);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 9, 0, 0);
    checks++;
    if (depth_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL one_instr_pop: got depth=%0d expected 0", depth_o);
    end
    tick();
  endtask

  task automatic test_reset_midloop();
    logic [15:0] pcs [3] = '{4, 5, 6};
    do_reset();
    applyStimulus(1, 4, 6, 3, 0, 0, 0);
    tick();
    foreach (pcs[i]) begin
      applyStimulus(0, 0, 0, 0, pcs[i], 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 6, 0, 0);
    checks++;
    if (iter_o !== 16'd2) begin
      errors++;
      $display("[TB] FAIL midloop_iter: got %0d expected 2", iter_o);
    end
    #2;
    reset = 1'b1;
    stk.delete();
    mOvf = 1'b0;
    #1;
    checks++;
    if (got !== 39'd1) begin
      errors++;
      $display("[TB] FAIL midloop_reset: got %h expected %h", got, 39'd1);
    end
    tick();
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] s;
    logic [15:0] pc;
    int sel;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      if (stk.size() > 0 && sel <= 1)      pc = stk[$].e;
      else if (stk.size() > 0 && sel == 2) pc = stk[$].s;
      else                                 pc = 16'($urandom_range(0, 63));
      s = 16'($urandom_range(0, 40));
      applyStimulus(($urandom_range(0, 99) < 15), s, s + 16'($urandom_range(0, 4)),
                    16'($urandom_range(0, 4)), pc,
                    ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 2));
      checks++;
      if (got !== expected()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, got, expected());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_stall();
    test_nested();
    test_overflow();
    test_flush();
    test_zero_count();
    test_reset_midloop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
